// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Control unit for the stopwatch digit counters. Conditions two raw buttons
// (2-flop sync + debounce + rising-edge event), runs the IDLE/RUN/PAUSE/LAP
// FSM and generates the TICK_HZ count enable from the system clock.
//
// Ports:
//   clk             system clock, all flops on rising edge
//   reset           synchronous, active-high reset
//   btn_start_stop  raw asynchronous button, active-high
//   btn_lap_reset   raw asynchronous button, active-high
//   tick_en         one-cycle count-enable pulse at TICK_HZ while running
//   clear           one-cycle pulse zeroing the digit counters
//   hold            display freeze level (LAP)
//   running         high in RUN or LAP
//   state           IDLE=00, RUN=01, PAUSE=10, LAP=11
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int unsigned CLK_HZ          = 100000000,
    parameter int unsigned TICK_HZ         = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start_stop,
    input  logic       btn_lap_reset,
    output logic       tick_en,
    output logic       clear,
    output logic       hold,
    output logic       running,
    output logic [1:0] state
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned PRE_W = $clog2(DIV);
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned NBTN  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

    // Index 0 = start/stop, index 1 = lap/reset
    logic [NBTN-1:0]            r_sync1;
    logic [NBTN-1:0]            r_sync2;
    logic [NBTN-1:0]            r_level;
    logic [NBTN-1:0]            r_evt;
    logic [NBTN-1:0][DEB_W-1:0] r_cnt;

    state_t             r_state;
    logic               r_hold;
    logic               r_running;
    logic               r_clear;
    logic               r_tick;
    logic [PRE_W-1:0]   r_pre;

    logic w_ss;
    logic w_lr;

    assign w_ss = r_evt[0];
    assign w_lr = r_evt[1];

    // Synchroniser and debouncer; an event fires only when the debounced
    // level flips from 0 to 1
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_evt   <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= {btn_lap_reset, btn_start_stop};
            r_sync2 <= r_sync1;
            for (int i = 0; i < int'(NBTN); i++) begin
                r_evt[i] <= 1'b0;
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_level[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                    r_evt[i]   <= r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // FSM with registered decoded outputs, plus the prescaler. The tick is
    // judged on the current running level, so a tick due in the cycle that
    // leaves RUN/LAP is still issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_hold    <= 1'b0;
            r_running <= 1'b0;
            r_clear   <= 1'b0;
            r_tick    <= 1'b0;
            r_pre     <= '0;
        end else begin
            r_clear <= 1'b0;
            r_tick  <= 1'b0;

            if (r_running) begin
                if (r_pre == PRE_W'(DIV - 1)) begin
                    r_pre  <= '0;
                    r_tick <= 1'b1;
                end else begin
                    r_pre <= r_pre + PRE_W'(1);
                end
            end

            // ss has priority; a simultaneous lr is dropped
            case (r_state)
                ST_IDLE: begin
                    r_pre <= '0;
                    if (w_ss) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end else if (w_lr) begin
                        r_clear <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_ss) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                    end else if (w_lr) begin
                        r_state <= ST_LAP;
                        r_hold  <= 1'b1;
                    end
                end
                ST_LAP: begin
                    if (w_ss) begin
                        r_state   <= ST_PAUSE;
                        r_hold    <= 1'b0;
                        r_running <= 1'b0;
                    end else if (w_lr) begin
                        r_state <= ST_RUN;
                        r_hold  <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (w_ss) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end else if (w_lr) begin
                        r_state <= ST_IDLE;
                        r_clear <= 1'b1;
                        r_pre   <= '0;
                    end
                end
            endcase
        end
    end

    assign tick_en = r_tick;
    assign clear   = r_clear;
    assign hold    = r_hold;
    assign running = r_running;
    assign state   = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed scoreboard bench for stopwatch_ctrl with CLK_HZ=100, TICK_HZ=10,
// DEBOUNCE_CYCLES=4. Stimulus pushes the expected output events (cycle and
// output vector); the monitor pops one whenever the state changes or a
// tick/clear pulse appears.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_ss;
    logic       btn_lr;
    logic       tick_en;
    logic       clear;
    logic       hold;
    logic       running;
    logic [1:0] state;

    stopwatch_ctrl #(
        .CLK_HZ         (100),
        .TICK_HZ        (10),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_start_stop(btn_ss),
        .btn_lap_reset (btn_lr),
        .tick_en       (tick_en),
        .clear         (clear),
        .hold          (hold),
        .running       (running),
        .state         (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [5:0] o;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  e_mon;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [5:0] w_o;
    logic [5:0] prev_o = '0;
    assign w_o = {state, hold, running, clear, tick_en};

    // Monitor: an event is any change of state/hold/running or a pulse
    always @(negedge clk) begin
        if (w_o[5:2] != prev_o[5:2] || w_o[1] || w_o[0]) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d got {st,hold,run,clr,tick}=%b required none",
                         cyc, w_o);
            end else begin
                e_mon = exp_q.pop_front();
                if (e_mon.cyc != cyc || e_mon.o != w_o) begin
                    n_fail++;
                    $display("FAIL event got cyc=%0d out=%b required cyc=%0d out=%b",
                             cyc, w_o, e_mon.cyc, e_mon.o);
                end
            end
        end
        prev_o = w_o;
    end

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int t, input logic [1:0] st, input logic h,
                        input logic r, input logic c, input logic k);
        ev_t e;
        e.cyc = t;
        e.o   = {st, h, r, c, k};
        exp_q.push_back(e);
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if (w_o !== 6'b000000) begin
            n_fail++;
            $display("FAIL %s got out=%b required 000000", name, w_o);
        end
    endtask

    int t;
    int e0;

    initial begin
        reset  = 1'b1;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_state");
        reset = 1'b0;

        // Bounce: toggling every 2 cycles never reaches 4 stable samples
        t = cyc + 2;
        wait_to(t);
        for (int i = 0; i < 15; i++) begin
            btn_ss = (i % 2 == 0);
            wait_to(t + 2 * (i + 1));
        end
        btn_ss = 1'b0;
        wait_to(cyc + 12);

        // IDLE + lr: clear pulse only
        t = cyc;
        btn_lr = 1'b1;
        push(t + 7, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_to(t + 10);
        btn_lr = 1'b0;
        wait_to(t + 20);

        // Clean start, held for 20 cycles
        t  = cyc;
        e0 = t + 7;
        btn_ss = 1'b1;
        push(e0,      2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        push(e0 + 10, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
        push(e0 + 20, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_to(t + 20);
        btn_ss = 1'b0;

        // Lap, tick continues during LAP
        wait_to(e0 + 14);
        btn_lr = 1'b1;
        push(e0 + 21, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        push(e0 + 30, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_to(e0 + 22);
        btn_lr = 1'b0;

        // Unlap
        wait_to(e0 + 29);
        btn_lr = 1'b1;
        push(e0 + 36, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);

        // Pause 37 cycles after RUN entry: prescaler phase 7 is kept
        wait_to(e0 + 30);
        btn_ss = 1'b1;
        push(e0 + 37, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_to(e0 + 37);
        btn_lr = 1'b0;
        wait_to(e0 + 40);
        btn_ss = 1'b0;

        // Resume: first tick 3 cycles after re-entering RUN
        wait_to(e0 + 50);
        btn_ss = 1'b1;
        push(e0 + 57, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        push(e0 + 60, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
        push(e0 + 70, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_to(e0 + 58);
        btn_ss = 1'b0;

        // Simultaneous ss and lr in RUN: PAUSE, no LAP, no clear
        wait_to(e0 + 65);
        btn_ss = 1'b1;
        btn_lr = 1'b1;
        push(e0 + 72, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_to(e0 + 73);
        btn_ss = 1'b0;
        btn_lr = 1'b0;

        // PAUSE + lr: IDLE with clear, prescaler zeroed
        wait_to(e0 + 80);
        btn_lr = 1'b1;
        push(e0 + 87, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_to(e0 + 88);
        btn_lr = 1'b0;

        // Restart: a zeroed prescaler gives the first tick 10 cycles in
        wait_to(e0 + 95);
        btn_ss = 1'b1;
        push(e0 + 102, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        push(e0 + 112, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_to(e0 + 103);
        btn_ss = 1'b0;

        // Reset on the edge where a tick is due: everything reads 0
        wait_to(e0 + 121);
        reset = 1'b1;
        push(e0 + 122, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_to(e0 + 124);
        reset = 1'b0;

        wait_to(e0 + 140);
        check_idle("post_reset_idle");

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events got %0d outstanding required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
